// File: rtl/frame_ecc_scrub_ctrl.sv
// Frame ECC scrub controller: classifies syndrome events, queues single-bit corrections and
// issues them one at a time over a REQ/ACK handshake; keeps sticky status and saturating counters.
//
// state | meaning
// IDLE  | no correction in flight; leave when the queue holds an entry
// LOAD  | pop queue head into CORR_FAR/CORR_WORD/CORR_BIT, clear timer
// REQ   | CORR_REQ high, waiting for CORR_ACK or timeout
module frame_ecc_scrub_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             ENABLE,
    input  logic             SYNDROMEVALID,
    input  logic             ECCERROR,
    input  logic             ECCERRORSINGLE,
    input  logic             CRCERROR,
    input  logic [23:0]      FAR,
    input  logic [6:0]       SYNWORD,
    input  logic [4:0]       SYNBIT,
    output logic             CORR_REQ,
    output logic [23:0]      CORR_FAR,
    output logic [6:0]       CORR_WORD,
    output logic [4:0]       CORR_BIT,
    input  logic             CORR_ACK,
    input  logic             CLR_STATUS,
    output logic             UNCORR,
    output logic [23:0]      UNCORR_FAR,
    output logic             CRC_ERR,
    output logic             OVERFLOW,
    output logic             TIMEOUT_ERR,
    output logic [CNT_W-1:0] CORR_CNT,
    output logic [CNT_W-1:0] UNCORR_CNT,
    output logic             BUSY
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0]    T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [AW:0]      Q_FULL  = (AW + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_REQ  = 2'd2
    } state_t;

    state_t        state;
    logic [35:0]   q_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   q_cnt;
    logic [TW-1:0] timer;
    logic          crc_q;

    logic ev, corr_ev, uncorr_ev, pop, push, q_full;
    logic ack_done, to_hit, crc_rise;

    assign ev        = SYNDROMEVALID & ENABLE & ECCERROR;
    assign corr_ev   = ev & ECCERRORSINGLE;
    assign uncorr_ev = ev & ~ECCERRORSINGLE;
    assign pop       = (state == S_LOAD);
    assign q_full    = (q_cnt == Q_FULL);
    // a pop in the same cycle frees the slot the push needs
    assign push      = corr_ev & (~q_full | pop);
    assign ack_done  = (state == S_REQ) & CORR_ACK;
    assign to_hit    = (state == S_REQ) & ~CORR_ACK & (timer == T_LAST);
    assign crc_rise  = CRCERROR & ~crc_q;
    assign BUSY      = (q_cnt != '0) | (state != S_IDLE);

    always_ff @(posedge CLK) begin
        if (push) q_mem[wr_ptr] <= {FAR, SYNWORD, SYNBIT};
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   q_cnt <= q_cnt + 1'b1;
                2'b01:   q_cnt <= q_cnt - 1'b1;
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= S_IDLE;
            CORR_REQ  <= 1'b0;
            CORR_FAR  <= '0;
            CORR_WORD <= '0;
            CORR_BIT  <= '0;
            timer     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (q_cnt != '0) state <= S_LOAD;
                end
                S_LOAD: begin
                    {CORR_FAR, CORR_WORD, CORR_BIT} <= q_mem[rd_ptr];
                    timer    <= '0;
                    CORR_REQ <= 1'b1;
                    state    <= S_REQ;
                end
                S_REQ: begin
                    if (CORR_ACK || timer == T_LAST) begin
                        CORR_REQ <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    CORR_REQ <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            crc_q       <= 1'b0;
            UNCORR      <= 1'b0;
            UNCORR_FAR  <= '0;
            CRC_ERR     <= 1'b0;
            OVERFLOW    <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
            CORR_CNT    <= '0;
            UNCORR_CNT  <= '0;
        end else begin
            crc_q <= CRCERROR;
            if (CLR_STATUS) begin
                UNCORR      <= 1'b0;
                UNCORR_FAR  <= '0;
                CRC_ERR     <= 1'b0;
                OVERFLOW    <= 1'b0;
                TIMEOUT_ERR <= 1'b0;
                CORR_CNT    <= '0;
                UNCORR_CNT  <= '0;
            end else begin
                if (uncorr_ev) begin
                    UNCORR <= 1'b1;
                    if (!UNCORR)                UNCORR_FAR <= FAR;
                    if (UNCORR_CNT != CNT_MAX) UNCORR_CNT <= UNCORR_CNT + 1'b1;
                end
                if (crc_rise)          CRC_ERR     <= 1'b1;
                if (corr_ev && !push)  OVERFLOW    <= 1'b1;
                if (to_hit)            TIMEOUT_ERR <= 1'b1;
                if (ack_done && CORR_CNT != CNT_MAX) CORR_CNT <= CORR_CNT + 1'b1;
            end
        end
    end

endmodule
